// File: rtl/d_cache_loader.sv
// d_cache_loader: receives a byte stream over valid/ready, packs the bytes
// little-endian into DPW-bit words and writes them to the d_cache preload
// port at consecutive word addresses, starting from a latched base address.
module d_cache_loader #(
  parameter int DPW      = 32,
  parameter int Depth    = 120,
  parameter int CntWidth = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DPW-1:0]      base_addr,
  input  logic [CntWidth-1:0] word_count,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic                byte_ready,
  output logic                data_en,
  output logic [DPW-1:0]      input_data,
  output logic [DPW-1:0]      input_addr,
  output logic                busy,
  output logic                done,
  output logic                err_range
);

  // Wide enough that base + 4*count can never wrap during the bounds check.
  localparam int SumW = DPW + CntWidth + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DPW-1:0]        r_addr;
  logic [DPW-1:0]        r_word;
  logic [DPW-1:0]        r_input_data;
  logic [DPW-1:0]        r_input_addr;
  logic [CntWidth-1:0]   r_words_left;
  logic [1:0]            r_byte_idx;
  logic                  r_err_range;

  logic [SumW-1:0]       w_end_addr;
  logic                  w_over;
  logic                  w_xfer;
  logic                  w_last_byte;
  logic [DPW-1:0]        w_word_next;

  // Request bounds check: one past the last byte written must not exceed Depth.
  assign w_end_addr  = SumW'(base_addr) + SumW'({word_count, 2'b00});
  assign w_over      = w_end_addr > SumW'(Depth);
  assign w_xfer      = byte_valid && (r_state == S_COLLECT);
  assign w_last_byte = (r_byte_idx == 2'd3);

  // Merge the incoming byte into the lane selected by the byte index.
  always_comb begin
    w_word_next = r_word;
    w_word_next[{r_byte_idx, 3'b000} +: 8] = byte_data;
  end

  // Next-state logic and state-decoded handshake/strobe outputs.
  always_comb begin
    w_state_next = r_state;
    byte_ready   = 1'b0;
    data_en      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_over || (word_count == '0)) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid && w_last_byte) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        data_en = 1'b1;
        busy    = 1'b1;
        if (r_words_left == CntWidth'(1)) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_COLLECT;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath: latch the request, assemble words, advance address and count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_word       <= '0;
      r_input_data <= '0;
      r_input_addr <= '0;
      r_words_left <= '0;
      r_byte_idx   <= '0;
      r_err_range  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr       <= base_addr;
            r_words_left <= word_count;
            r_err_range  <= w_over;
            r_byte_idx   <= '0;
          end
        end
        S_COLLECT: begin
          if (w_xfer) begin
            r_word     <= w_word_next;
            r_byte_idx <= r_byte_idx + 2'd1;
            // Present the completed word during the WRITE cycle and hold it after.
            if (w_last_byte) begin
              r_input_data <= w_word_next;
              r_input_addr <= r_addr;
            end
          end
        end
        S_WRITE: begin
          r_addr       <= r_addr + DPW'(4);
          r_words_left <= r_words_left - CntWidth'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign input_data = r_input_data;
  assign input_addr = r_input_addr;
  assign err_range  = r_err_range;

endmodule

// File: tb/tb_d_cache_loader.sv
// Self-checking bench for d_cache_loader: directed and randomized loads
// compared against a word-level reference model of the expected writes.
module tb_d_cache_loader;

  localparam int DPW   = 32;
  localparam int DEPTH = 120;
  localparam int CW    = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [DPW-1:0]  base_addr;
  logic [CW-1:0]   word_count;
  logic            byte_valid;
  logic [7:0]      byte_data;
  logic            byte_ready;
  logic            data_en;
  logic [DPW-1:0]  input_data;
  logic [DPW-1:0]  input_addr;
  logic            busy;
  logic            done;
  logic            err_range;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  d_cache_loader #(.DPW(DPW), .Depth(DEPTH), .CntWidth(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .data_en    (data_en),
    .input_data (input_data),
    .input_addr (input_addr),
    .busy       (busy),
    .done       (done),
    .err_range  (err_range)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " data_en"},    data_en,    0);
    check({tag, " byte_ready"}, byte_ready, 0);
    check({tag, " busy"},       busy,       0);
    check({tag, " done"},       done,       0);
    check({tag, " err_range"},  err_range,  0);
    check({tag, " input_data"}, input_data, 0);
    check({tag, " input_addr"}, input_addr, 0);
  endtask

  // One load: build the expected write list, drive start and bytes, and
  // compare every observed write, the done pulse and the final flags.
  // seq_mode: 0 random bytes, 1 bytes 0,1,2..., 2 bytes 0x11,0x22,...
  task automatic run_load(input logic [31:0] base, input logic [15:0] cnt,
                          input int valid_pct, input bit hold_start,
                          input int seq_mode, input string name);
    logic [7:0]  bytes[$];
    logic [63:0] end_addr;
    logic [31:0] ea;
    logic [31:0] ed;
    bit          over;
    bit          finished;
    bit          xfer;
    int          nb;
    int          bi;
    int          cyc;
    int          last_wr;
    int          done_cyc;
    int          nwr;

    end_addr = 64'(base) + 64'(cnt) * 64'd4;
    over     = end_addr > 64'(DEPTH);
    nb       = over ? 0 : int'(cnt) * 4;
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int i = 0; i < nb; i++) begin
      if (seq_mode == 1)      bytes.push_back(8'(i));
      else if (seq_mode == 2) bytes.push_back(8'((i + 1) * 17));
      else                    bytes.push_back(8'($urandom_range(255)));
    end
    for (int w = 0; w < nb / 4; w++) begin
      exp_addr_q.push_back(base + 32'(4 * w));
      exp_data_q.push_back({bytes[4*w+3], bytes[4*w+2], bytes[4*w+1], bytes[4*w]});
    end

    start      = 1'b1;
    base_addr  = base;
    word_count = cnt;
    byte_valid = 1'b0;
    step();
    if (hold_start) begin
      base_addr  = 32'd0;
      word_count = 16'd1;
    end else begin
      start = 1'b0;
    end

    cyc = 1; bi = 0; finished = 0; last_wr = -1; done_cyc = -1; nwr = 0;
    while (!finished && cyc < 2000) begin
      check($sformatf("%s busy c%0d", name, cyc), busy, !done);
      if (data_en) begin
        check($sformatf("%s byte_ready in write c%0d", name, cyc), byte_ready, 0);
        if (last_wr >= 0) begin
          if (valid_pct >= 100)
            check($sformatf("%s write spacing", name), 64'(cyc - last_wr), 64'd5);
          else
            check($sformatf("%s write spacing>=5", name), (cyc - last_wr) >= 5, 1);
        end
        if (exp_addr_q.size() == 0) begin
          check($sformatf("%s unexpected write", name), 1, 0);
        end else begin
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          check($sformatf("%s addr w%0d", name, nwr), input_addr, ea);
          check($sformatf("%s data w%0d", name, nwr), input_data, ed);
        end
        last_wr = cyc;
        nwr++;
      end
      if (done) begin
        done_cyc = cyc;
        finished = 1;
        start    = 1'b0;
      end
      byte_valid = (bi < nb) && ($urandom_range(99) < valid_pct);
      byte_data  = byte_valid ? bytes[bi] : 8'($urandom_range(255));
      xfer       = byte_valid && byte_ready;
      if (xfer) bi++;
      step();
      cyc++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;

    check({name, " done seen"}, finished, 1);
    check({name, " writes left"}, 64'(exp_addr_q.size()), 0);
    check({name, " bytes consumed"}, 64'(bi), 64'(nb));
    if (nb == 0) check({name, " done latency"}, 64'(done_cyc), 64'd1);
    else         check({name, " done after last write"}, 64'(done_cyc), 64'(last_wr + 1));
    check({name, " err_range"}, err_range, over);
    check({name, " busy after"}, busy, 0);
    check({name, " done after"}, done, 0);
    check({name, " data_en after"}, data_en, 0);
    $display("load %s base=%0d count=%0d writes=%0d done_cycle=%0d err_range=%0b",
             name, base, cnt, nwr, done_cyc, err_range);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;

    run_load(32'd0,   16'd1, 100, 0, 2, "single");
    run_load(32'd8,   16'd3, 100, 0, 1, "burst3");
    run_load(32'd8,   16'd3,  50, 0, 1, "burst3_stall");
    run_load(32'd112, 16'd3, 100, 0, 1, "over_range");
    run_load(32'd112, 16'd2, 100, 0, 0, "top_fit");
    run_load(32'd0,   16'd0, 100, 0, 0, "zero_count");
    run_load(32'd20,  16'd2,  70, 1, 0, "start_held");

    // Reset while idle clears a sticky range error.
    run_load(32'd100, 16'd10, 100, 0, 0, "over_again");
    rst_n = 1'b0;
    step();
    check_all_zero("idle reset");
    rst_n = 1'b1;

    // Reset after two bytes of a word abandons the partial word.
    start = 1'b1; base_addr = 32'd0; word_count = 16'd1;
    step();
    start = 1'b0;
    byte_valid = 1'b1; byte_data = 8'hAA;
    step();
    byte_data = 8'hBB;
    step();
    rst_n = 1'b0; byte_data = 8'hCC;
    step();
    check_all_zero("midload reset");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      byte_data = 8'(i + 1);
      check($sformatf("post reset data_en c%0d", i), data_en, 0);
      check($sformatf("post reset byte_ready c%0d", i), byte_ready, 0);
      step();
    end
    byte_valid = 1'b0;
    $display("load midload_reset abandoned after 2 bytes");
    run_load(32'd0, 16'd1, 100, 0, 0, "fresh_after_reset");

    // Randomized loads, some of which exceed the d_cache size.
    for (int k = 0; k < 8; k++) begin
      run_load(32'($urandom_range(0, 100)), 16'($urandom_range(0, 8)),
               $urandom_range(30, 100), 0, 0, $sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
